// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder composed of two half adders and an OR on their carries.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1, c1, c2;

  assign s1   = a ^ b;
  assign c1   = a & b;
  assign s    = s1 ^ cin;
  assign c2   = s1 & cin;
  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: BITS_PER_CYCLE bits per clock, LSB chunk first, carry registered
// between chunks, with valid/ready handshakes on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_width
    $error("serial_adder: WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0]          a_sh, b_sh, sum_r;
  logic                      carry, c_out_r, ovf_r;
  logic [CW-1:0]             cnt;
  logic [BITS_PER_CYCLE:0]   cy;
  logic [BITS_PER_CYCLE-1:0] s_chunk;
  logic                      accept, last;

  assign cy[0] = carry;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
    full_adder_cell u_fa (
      .a    (a_sh[i]),
      .b    (b_sh[i]),
      .cin  (cy[i]),
      .s    (s_chunk[i]),
      .cout (cy[i+1])
    );
  end

  assign in_ready  = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == LAST);
  assign out_valid = (state == HOLD);
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign overflow  = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = in_valid ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      carry   <= 1'b0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == ADD) begin
      a_sh  <= a_sh >> BITS_PER_CYCLE;
      b_sh  <= b_sh >> BITS_PER_CYCLE;
      // Result chunks enter at the top and shift down, so chunk 0 lands at bit 0
      // after N cycles; this form stays legal when WIDTH == BITS_PER_CYCLE.
      sum_r <= (sum_r >> BITS_PER_CYCLE) | (WIDTH'(s_chunk) << (WIDTH - BITS_PER_CYCLE));
      carry <= cy[BITS_PER_CYCLE];
      cnt   <= cnt + 1'b1;
      if (last) begin
        c_out_r <= cy[BITS_PER_CYCLE];
        ovf_r   <= cy[BITS_PER_CYCLE] ^ cy[BITS_PER_CYCLE-1];
      end
    end
  end

endmodule
